// File: rtl/voxel_pkg.sv
// Shared voxel-world widths, address mapping and the tagged
// query result bundle.
package voxel_pkg;

    localparam int X_BITS    = 5;
    localparam int Y_BITS    = 5;
    localparam int Z_BITS    = 5;
    localparam int ADDR_BITS = X_BITS + Y_BITS + Z_BITS;
    localparam int TAG_BITS  = 4;

    typedef struct packed {
        logic                occupied;
        logic                oob;
        logic [TAG_BITS-1:0] tag;
    } voxel_result_t;

    function automatic logic [ADDR_BITS-1:0] voxel_addr(
        input logic [X_BITS-1:0] x,
        input logic [Y_BITS-1:0] y,
        input logic [Z_BITS-1:0] z
    );
        return {z, y, x};
    endfunction

endpackage

// File: rtl/voxel_result_fifo.sv
// Shift-register result FIFO: the head always sits in entry 0,
// so dout comes straight from a flop.
module voxel_result_fifo #(
    parameter  int W     = 6,
    parameter  int DEPTH = 3,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  din,
    input  logic          pop,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  ent [DEPTH];
    logic [W-1:0]  nxt [DEPTH];
    logic [CW-1:0] wr;

    assign wr   = count - CW'(pop);
    assign dout = ent[0];

    // Vacated slots shift in zero, so an empty FIFO shows all-zero data.
    always_comb begin
        nxt = ent;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nxt[i] = ent[i+1];
            end
            nxt[DEPTH-1] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (push && CW'(i) == wr) begin
                nxt[i] = din;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            ent   <= '{default: '0};
        end else begin
            count <= count + CW'(push) - CW'(pop);
            ent   <= nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push && !pop) begin
            assert (count < CW'(DEPTH))
            else $error("voxel_result_fifo overflow");
        end
    end

endmodule

// File: rtl/voxel_query_pipe.sv
// Occupancy lookup front end for a sync-read voxel RAM: one query
// per cycle in, tagged occupied/oob results out in issue order.
module voxel_query_pipe #(
    parameter int X_BITS    = 5,
    parameter int Y_BITS    = 5,
    parameter int Z_BITS    = 5,
    parameter int COORD_W   = 8,
    parameter int TAG_W     = 4,
    parameter int OUT_DEPTH = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           load_mode,
    input  logic                           q_valid,
    output logic                           q_ready,
    input  logic [COORD_W-1:0]             q_x,
    input  logic [COORD_W-1:0]             q_y,
    input  logic [COORD_W-1:0]             q_z,
    input  logic [TAG_W-1:0]               q_tag,
    output logic [X_BITS+Y_BITS+Z_BITS-1:0] ram_raddr,
    input  logic                           ram_rdata,
    output logic                           r_valid,
    input  logic                           r_ready,
    output logic                           r_occupied,
    output logic                           r_oob,
    output logic [TAG_W-1:0]               r_tag,
    output logic                           busy
);

    import voxel_pkg::*;

    localparam int RW = TAG_W + 2;
    localparam int CW = $clog2(OUT_DEPTH + 1);

    if (OUT_DEPTH < 2) begin : g_bad_depth
        $error("OUT_DEPTH must be at least 2");
    end

    logic             inflight;
    logic             fl_oob;
    logic [TAG_W-1:0] fl_tag;
    logic             oob;
    logic             accept;
    logic             pop;
    logic [CW-1:0]    count;
    logic [CW:0]      used;
    logic [RW-1:0]    din;
    logic [RW-1:0]    dout;

    assign ram_raddr = {q_z[Z_BITS-1:0], q_y[Y_BITS-1:0], q_x[X_BITS-1:0]};

    // In range means every bit above the index width is zero.
    assign oob = (|q_x[COORD_W-1:X_BITS])
               | (|q_y[COORD_W-1:Y_BITS])
               | (|q_z[COORD_W-1:Z_BITS]);

    // Credit check counts the in-flight read so the buffer never overflows.
    assign used    = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign q_ready = !rst && !load_mode && (used < (CW+1)'(OUT_DEPTH));
    assign accept  = q_valid && q_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= 1'b0;
            fl_oob   <= 1'b0;
            fl_tag   <= '0;
        end else begin
            inflight <= accept;
            if (accept) begin
                fl_oob <= oob;
                fl_tag <= q_tag;
            end
        end
    end

    assign din = {ram_rdata & ~fl_oob, fl_oob, fl_tag};
    assign pop = r_valid && r_ready;

    voxel_result_fifo #(
        .W     (RW),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (inflight),
        .din   (din),
        .pop   (pop),
        .dout  (dout),
        .count (count)
    );

    assign r_valid = count != '0;
    assign {r_occupied, r_oob, r_tag} = dout;
    assign busy = inflight | r_valid;

endmodule

// File: tb/tb_voxel_query_pipe.sv
// Randomized bench for voxel_query_pipe with a behavioural RAM
// and a queue-based model of query results.
module tb_voxel_query_pipe;

    import voxel_pkg::*;

    typedef struct packed {
        logic          v;
        voxel_result_t r;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_mode;
    logic        q_valid;
    logic        q_ready;
    logic [7:0]  q_x;
    logic [7:0]  q_y;
    logic [7:0]  q_z;
    logic [3:0]  q_tag;
    logic [14:0] ram_raddr;
    logic        ram_rdata;
    logic        r_valid;
    logic        r_ready;
    logic        r_occupied;
    logic        r_oob;
    logic [3:0]  r_tag;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int n_acc  = 0;
    int cyc    = 0;

    bit            mem [32768];
    voxel_result_t pend [$];
    rec_t          got_q [$];
    rec_t          exp_q [$];
    int            pop_cyc [$];
    rec_t          g_rec;
    rec_t          e_rec;

    voxel_query_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .load_mode  (load_mode),
        .q_valid    (q_valid),
        .q_ready    (q_ready),
        .q_x        (q_x),
        .q_y        (q_y),
        .q_z        (q_z),
        .q_tag      (q_tag),
        .ram_raddr  (ram_raddr),
        .ram_rdata  (ram_rdata),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_occupied (r_occupied),
        .r_oob      (r_oob),
        .r_tag      (r_tag),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_rdata <= mem[ram_raddr];
        cyc <= cyc + 1;
    end

    function automatic voxel_result_t model(
        int x, int y, int z, logic [3:0] t
    );
        voxel_result_t m;
        m.tag = t;
        m.oob = (x < 0 || x > 31 || y < 0 || y > 31 || z < 0 || z > 31);
        m.occupied = m.oob ? 1'b0 : mem[z * 1024 + y * 32 + x];
        return m;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            pend.delete();
        end else begin
            if (r_valid === 1'b1 && r_ready === 1'b1) begin
                g_rec.v = 1'b1;
                g_rec.r.occupied = r_occupied;
                g_rec.r.oob = r_oob;
                g_rec.r.tag = r_tag;
                if (pend.size() > 0) begin
                    e_rec.v = 1'b1;
                    e_rec.r = pend.pop_front();
                end else begin
                    e_rec = '0;
                end
                got_q.push_back(g_rec);
                exp_q.push_back(e_rec);
                pop_cyc.push_back(cyc);
            end
            if (q_valid === 1'b1 && q_ready === 1'b1) begin
                pend.push_back(model($signed(q_x), $signed(q_y),
                                     $signed(q_z), q_tag));
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_q(int x, int y, int z, logic [3:0] t);
        q_x = x[7:0];
        q_y = y[7:0];
        q_z = z[7:0];
        q_tag = t;
    endtask

    task automatic rnd_q(logic [3:0] t);
        set_q(int'($urandom_range(0, 40)) - 4,
              int'($urandom_range(0, 40)) - 4,
              int'($urandom_range(0, 40)) - 4, t);
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_log();
        got_q.delete();
        exp_q.delete();
        pop_cyc.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        load_mode = 1'b0;
        q_valid = 1'b0;
        r_ready = 1'b0;
        set_q(0, 0, 0, 4'd0);
        repeat (3) tick();
        @(negedge clk);
        n_chk++;
        if (r_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_r_valid: got %b want 0", r_valid);
        end
        n_chk++;
        if (r_occupied !== 1'b0) begin
            n_fail++; $display("FAIL reset_r_occ: got %b want 0", r_occupied);
        end
        n_chk++;
        if (r_oob !== 1'b0) begin
            n_fail++; $display("FAIL reset_r_oob: got %b want 0", r_oob);
        end
        n_chk++;
        if (r_tag !== 4'd0) begin
            n_fail++; $display("FAIL reset_r_tag: got %h want 0", r_tag);
        end
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        n_chk++;
        if (q_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_q_ready: got %b want 0", q_ready);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (q_ready !== 1'b1) begin
            n_fail++; $display("FAIL post_reset_q_ready: got %b want 1", q_ready);
        end
    endtask

    task automatic test_single();
        bit ok;
        for (int i = 0; i < 32768; i++) mem[i] = 1'b0;
        mem[5 * 1024 + 4 * 32 + 3] = 1'b1;
        clear_log();
        tick();
        r_ready = 1'b1;
        set_q(3, 4, 5, 4'd7);
        q_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if (ram_raddr !== 15'h1483) begin
            n_fail++; $display("FAIL single_raddr: got %h want 1483", ram_raddr);
        end
        n_chk++;
        if (q_ready !== 1'b1) begin
            n_fail++; $display("FAIL single_q_ready: got %b want 1", q_ready);
        end
        tick();
        q_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if (r_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_n1: r_valid %b busy %b want 0 1", r_valid, busy);
        end
        @(negedge clk);
        n_chk++;
        if ({r_valid, r_occupied, r_oob, r_tag} !== {3'b110, 4'd7}) begin
            n_fail++;
            $display("FAIL single_n2: got v%b o%b b%b t%h want v1 o1 b0 t7",
                     r_valid, r_occupied, r_oob, r_tag);
        end
        wait_idle(ok);
        n_chk++;
        if (!ok || got_q.size() != 1) begin
            n_fail++; $display("FAIL single_count: got %0d want 1", got_q.size());
        end else begin
            n_chk++;
            if (got_q[0] !== exp_q[0]) begin
                n_fail++;
                $display("FAIL single_res: got %h want %h", got_q[0], exp_q[0]);
            end
        end
    endtask

    task automatic test_oob();
        bit ok;
        mem[31 * 1024] = 1'($urandom_range(0, 1));
        clear_log();
        tick();
        r_ready = 1'b1;
        q_valid = 1'b1;
        set_q(-1, 0, 0, 4'd1);
        tick();
        set_q(32, 0, 0, 4'd2);
        tick();
        set_q(0, 0, 31, 4'd3);
        tick();
        q_valid = 1'b0;
        wait_idle(ok);
        n_chk++;
        if (!ok || got_q.size() != 3) begin
            n_fail++; $display("FAIL oob_count: got %0d want 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL oob_res%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
                n_chk++;
                if (got_q[i].r.tag !== 4'(i + 1)) begin
                    n_fail++;
                    $display("FAIL oob_tag%0d: got %h want %0d", i, got_q[i].r.tag, i + 1);
                end
            end
            n_chk++;
            if ({got_q[0].r.oob, got_q[1].r.oob, got_q[2].r.oob} !== 3'b110) begin
                n_fail++;
                $display("FAIL oob_flags: got %b%b%b want 110",
                         got_q[0].r.oob, got_q[1].r.oob, got_q[2].r.oob);
            end
            n_chk++;
            if (got_q[2].r.occupied !== mem[31 * 1024]) begin
                n_fail++;
                $display("FAIL oob_edge_occ: got %b want %b",
                         got_q[2].r.occupied, mem[31 * 1024]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n0;
        for (int i = 0; i < 32768; i++) mem[i] = 1'($urandom_range(0, 1));
        clear_log();
        tick();
        r_ready = 1'b1;
        n0 = n_acc;
        for (int i = 0; i < 100; i++) begin
            rnd_q(4'(i));
            q_valid = 1'b1;
            tick();
        end
        q_valid = 1'b0;
        n_chk++;
        if (n_acc - n0 != 100) begin
            n_fail++; $display("FAIL b2b_accepts: got %0d want 100", n_acc - n0);
        end
        wait_idle(ok);
        n_chk++;
        if (!ok || got_q.size() != 100) begin
            n_fail++; $display("FAIL b2b_count: got %0d want 100", got_q.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                n_chk++;
                if (got_q[i] !== exp_q[i] || got_q[i].r.tag !== 4'(i)) begin
                    n_fail++;
                    $display("FAIL b2b_res%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
            n_chk++;
            if (pop_cyc[99] - pop_cyc[0] != 99) begin
                n_fail++;
                $display("FAIL b2b_gaps: got span %0d want 99", pop_cyc[99] - pop_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int n0;
        clear_log();
        tick();
        r_ready = 1'b0;
        n0 = n_acc;
        for (int i = 0; i < 8; i++) begin
            rnd_q(4'(i + 3));
            q_valid = 1'b1;
            @(negedge clk);
            if (r_valid === 1'b1) begin
                n_chk++;
                if (pend.size() == 0 ||
                    {r_occupied, r_oob, r_tag} !== pend[0]) begin
                    n_fail++;
                    $display("FAIL bp_hold%0d: got %b%b%h", i, r_occupied, r_oob, r_tag);
                end
            end
            @(posedge clk);
            #1;
        end
        n_chk++;
        if (n_acc - n0 != 3) begin
            n_fail++; $display("FAIL bp_accepts: got %0d want 3", n_acc - n0);
        end
        @(negedge clk);
        n_chk++;
        if (q_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_q_ready: got %b want 0", q_ready);
        end
        tick();
        r_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rnd_q(4'(i + 11));
            tick();
        end
        q_valid = 1'b0;
        wait_idle(ok);
        n_chk++;
        if (!ok || got_q.size() != n_acc - n0 || got_q.size() <= 3) begin
            n_fail++;
            $display("FAIL bp_count: got %0d want %0d (>3)", got_q.size(), n_acc - n0);
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                n_chk++;
                if (got_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL bp_res%0d: got %h want %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_load_mode();
        bit ok;
        int n0;
        clear_log();
        tick();
        r_ready = 1'b1;
        n0 = n_acc;
        rnd_q(4'd9);
        q_valid = 1'b1;
        @(negedge clk);
        n_chk++;
        if (q_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_pre_ready: got %b want 1", q_ready);
        end
        @(posedge clk);
        #1;
        load_mode = 1'b1;
        @(negedge clk);
        n_chk++;
        if (q_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_block: q_ready %b busy %b want 0 1", q_ready, busy);
        end
        repeat (4) tick();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || n_acc - n0 != 1 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL load_drain: busy %b acc %0d res %0d want 0 1 1",
                     busy, n_acc - n0, got_q.size());
        end else begin
            n_chk++;
            if (got_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL load_res: got %h want %h", got_q[0], exp_q[0]);
            end
        end
        @(posedge clk);
        #1;
        q_valid = 1'b0;
        load_mode = 1'b0;
        @(negedge clk);
        n_chk++;
        if (q_ready !== 1'b1) begin
            n_fail++; $display("FAIL load_restore: got %b want 1", q_ready);
        end
        wait_idle(ok);
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_log();
        tick();
        r_ready = 1'b0;
        q_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rnd_q(4'(i + 12));
            tick();
        end
        q_valid = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({busy, r_valid, q_ready} !== 3'b110) begin
            n_fail++;
            $display("FAIL rmid_pre: busy/r_valid/q_ready %b%b%b want 110",
                     busy, r_valid, q_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if ({r_valid, busy, q_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rmid_post: r_valid/busy/q_ready %b%b%b want 001",
                     r_valid, busy, q_ready);
        end
        @(posedge clk);
        #1;
        r_ready = 1'b1;
        repeat (5) tick();
        n_chk++;
        if (got_q.size() != 0) begin
            n_fail++; $display("FAIL rmid_stale: got %0d results want 0", got_q.size());
        end
        rnd_q(4'd5);
        q_valid = 1'b1;
        tick();
        q_valid = 1'b0;
        wait_idle(ok);
        n_chk++;
        if (!ok || got_q.size() != 1) begin
            n_fail++; $display("FAIL rmid_resume: got %0d want 1", got_q.size());
        end else begin
            n_chk++;
            if (got_q[0] !== exp_q[0]) begin
                n_fail++; $display("FAIL rmid_res: got %h want %h", got_q[0], exp_q[0]);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_oob();
        test_back_to_back();
        test_backpressure();
        test_load_mode();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
